// File: rtl/mixer_sequencer.sv
// mixer_sequencer
// Four-channel time-multiplexed mixer. A sample_tick snapshots the four
// channel samples, then one shared signed 16x16 MAC walks the channels
// (one per cycle). The 34-bit sum is scaled by 2^-14, saturated to Q16.0 and
// presented on pcm_out with a one-cycle pcm_valid strobe. Each channel's
// applied level ramps toward its target by at most RAMP_STEP per frame.
//
// Handshake: sample_tick is a one-cycle request accepted only while idle
// (busy=0); a tick while busy is dropped and recorded in the sticky overrun
// flag. pcm_valid is a one-cycle strobe with no back-pressure.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   sample_tick        frame start request
//   input_1..input_4   signed Q16.0 channel samples
//   lvl_1..lvl_4       signed Q2.14 target levels
//   mute               bit i-1 forces target of channel i to 0
//   clear_flags        clears clipped and overrun (a same-cycle set wins)
//   pcm_out            signed Q16.0 mix, held between frames
//   pcm_valid          one-cycle strobe when pcm_out updates
//   busy               frame in progress
//   clipped, overrun   sticky status flags
module mixer_sequencer #(
  parameter logic [15:0] RAMP_STEP = 16'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic [15:0] input_1,
  input  logic [15:0] input_2,
  input  logic [15:0] input_3,
  input  logic [15:0] input_4,
  input  logic [15:0] lvl_1,
  input  logic [15:0] lvl_2,
  input  logic [15:0] lvl_3,
  input  logic [15:0] lvl_4,
  input  logic [3:0]  mute,
  input  logic        clear_flags,
  output logic [15:0] pcm_out,
  output logic        pcm_valid,
  output logic        busy,
  output logic        clipped,
  output logic        overrun
);

  typedef enum logic {IDLE, MAC} state_t;

  state_t state, state_next;

  logic signed [15:0] snap    [4];
  logic signed [15:0] cur_lvl [4];
  logic signed [33:0] acc;
  logic [1:0]         ch;

  // MAC datapath for the channel selected by ch
  logic signed [15:0] cur_sel;
  logic signed [15:0] snap_sel;
  logic signed [15:0] target;
  logic signed [31:0] product;
  logic signed [16:0] diff;
  logic [16:0]        abs_diff;
  logic signed [16:0] stepped;
  logic signed [15:0] new_lvl;
  logic signed [33:0] sum;
  logic signed [33:0] res;
  logic [15:0]        sat_val;
  logic               sat_hit;
  logic               last_ch;

  assign busy    = (state == MAC);
  assign last_ch = (state == MAC) && (ch == 2'd3);

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick) state_next = MAC;
      MAC:     if (ch == 2'd3)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cur_sel  = cur_lvl[ch];
    snap_sel = snap[ch];
    target   = 16'sd0;
    case (ch)
      2'd0:    target = $signed(lvl_1);
      2'd1:    target = $signed(lvl_2);
      2'd2:    target = $signed(lvl_3);
      default: target = $signed(lvl_4);
    endcase
    if (mute[ch]) target = 16'sd0;

    // Product uses the level applied before this frame's ramp update.
    product  = cur_sel * snap_sel;

    // 17-bit difference so the full 16-bit swing cannot overflow.
    diff     = {target[15], target} - {cur_sel[15], cur_sel};
    abs_diff = diff[16] ? 17'(-diff) : 17'(diff);
    if (diff[16])
      stepped = {cur_sel[15], cur_sel} - $signed({1'b0, RAMP_STEP});
    else
      stepped = {cur_sel[15], cur_sel} + $signed({1'b0, RAMP_STEP});
    // A non-snapping step lands strictly between cur and target, so it fits.
    if (abs_diff <= {1'b0, RAMP_STEP})
      new_lvl = target;
    else
      new_lvl = stepped[15:0];

    sum = acc + {{2{product[31]}}, product};
    res = sum >>> 14;
    sat_hit = 1'b0;
    sat_val = res[15:0];
    if (res > 34'sd32767) begin
      sat_val = 16'h7FFF;
      sat_hit = 1'b1;
    end else if (res < -34'sd32768) begin
      sat_val = 16'h8000;
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      ch        <= 2'd0;
      pcm_out   <= 16'h0000;
      pcm_valid <= 1'b0;
      clipped   <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        snap[i]    <= 16'sd0;
        cur_lvl[i] <= 16'sd0;
      end
    end else begin
      state     <= state_next;
      pcm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            snap[0] <= $signed(input_1);
            snap[1] <= $signed(input_2);
            snap[2] <= $signed(input_3);
            snap[3] <= $signed(input_4);
            acc     <= '0;
            ch      <= 2'd0;
          end
        end
        MAC: begin
          acc         <= sum;
          cur_lvl[ch] <= new_lvl;
          ch          <= ch + 2'd1;
          if (ch == 2'd3) begin
            pcm_out   <= sat_val;
            pcm_valid <= 1'b1;
          end
        end
        default: ;
      endcase
      // Sticky flags: a set event in the same cycle beats clear_flags.
      clipped <= (last_ch && sat_hit) || (clipped && !clear_flags);
      overrun <= (busy && sample_tick) || (overrun && !clear_flags);
    end
  end

endmodule

// File: tb/tb_mixer_sequencer.sv
// tb_mixer_sequencer
// Two instances share all stimulus: dut_f with RAMP_STEP=0x8000 (instant
// gain) and dut_s with the default ramp step. An integer reference model per
// instance produces the expected pcm_out of every accepted frame; values are
// queued at tick time and popped whenever the matching pcm_valid appears.
module tb_mixer_sequencer;

  logic clk;
  logic reset;
  logic sample_tick;
  logic signed [15:0] in_v  [4];
  logic signed [15:0] lvl_v [4];
  logic [3:0] mute;
  logic clear_flags;

  logic [15:0] pcm_f, pcm_s;
  logic valid_f, valid_s, busy_f, busy_s, clip_f, clip_s, ovr_f, ovr_s;

  logic [15:0] exp_f[$];
  logic [15:0] exp_s[$];

  int n_cmp = 0;
  int n_bad = 0;

  int cur_m [2][4];
  int step_m [2];

  mixer_sequencer #(.RAMP_STEP(16'h8000)) dut_f (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .input_1(in_v[0]), .input_2(in_v[1]), .input_3(in_v[2]), .input_4(in_v[3]),
    .lvl_1(lvl_v[0]), .lvl_2(lvl_v[1]), .lvl_3(lvl_v[2]), .lvl_4(lvl_v[3]),
    .mute(mute), .clear_flags(clear_flags),
    .pcm_out(pcm_f), .pcm_valid(valid_f), .busy(busy_f),
    .clipped(clip_f), .overrun(ovr_f)
  );

  mixer_sequencer dut_s (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .input_1(in_v[0]), .input_2(in_v[1]), .input_3(in_v[2]), .input_4(in_v[3]),
    .lvl_1(lvl_v[0]), .lvl_2(lvl_v[1]), .lvl_3(lvl_v[2]), .lvl_4(lvl_v[3]),
    .mute(mute), .clear_flags(clear_flags),
    .pcm_out(pcm_s), .pcm_valid(valid_s), .busy(busy_s),
    .clipped(clip_s), .overrun(ovr_s)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: one frame for instance d, advancing its level state.
  function automatic logic [15:0] model_frame(input int d);
    longint acc;
    int tgt, diff, res;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      acc += longint'(cur_m[d][i]) * longint'(in_v[i]);
      tgt  = mute[i] ? 0 : int'(lvl_v[i]);
      diff = tgt - cur_m[d][i];
      if (diff <= step_m[d] && diff >= -step_m[d]) cur_m[d][i] = tgt;
      else if (diff > 0) cur_m[d][i] += step_m[d];
      else cur_m[d][i] -= step_m[d];
    end
    acc = acc >>> 14;
    if (acc > 32767) res = 32767;
    else if (acc < -32768) res = -32768;
    else res = int'(acc);
    return res[15:0];
  endfunction

  // Scoreboard: compare every pcm_valid against the queued expectation.
  always @(negedge clk) begin
    if (valid_f) begin
      if (exp_f.size() == 0) check_eq("unexpected_valid_f", 1, 0);
      else check_eq("pcm_f", $signed(pcm_f), $signed(exp_f.pop_front()));
    end
    if (valid_s) begin
      if (exp_s.size() == 0) check_eq("unexpected_valid_s", 1, 0);
      else check_eq("pcm_s", $signed(pcm_s), $signed(exp_s.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    exp_f.push_back(model_frame(0));
    exp_s.push_back(model_frame(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) cur_m[d][i] = 0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
  endtask

  // Full frame with cycle-accurate busy/valid checks; ends in cycle 6.
  task automatic run_frame();
    push_expected();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check_eq("busy_mac", busy_f, 1);
      check_eq("valid_early", valid_f, 0);
      step();
    end
    check_eq("valid_c5", valid_f, 1);
    check_eq("busy_c5", busy_f, 0);
    step();
    check_eq("valid_one_cycle", valid_f, 0);
  endtask

  task automatic set_chan(input int i, input int lv, input int iv);
    lvl_v[i] = 16'(lv);
    in_v[i]  = 16'(iv);
  endtask

  initial begin
    step_m[0] = 32768;
    step_m[1] = 64;
    reset = 1'b1;
    sample_tick = 1'b0;
    mute = 4'h0;
    clear_flags = 1'b0;
    for (int i = 0; i < 4; i++) set_chan(i, 0, 0);
    step();
    do_reset();

    // Reset state
    check_eq("rst_pcm", pcm_f, 0);
    check_eq("rst_valid", valid_f, 0);
    check_eq("rst_busy", busy_f, 0);
    check_eq("rst_clipped", clip_f, 0);
    check_eq("rst_overrun", ovr_f, 0);
    check_eq("rst_pcm_s", pcm_s, 0);

    // Instant gain
    set_chan(0, 16'h4000, 1000);
    set_chan(1, 16'h2000, 2000);
    set_chan(2, 16'h2000, -400);
    set_chan(3, 16'hC000, 500);
    run_frame();
    check_eq("gain_frame1", $signed(pcm_f), 0);
    run_frame();
    check_eq("gain_frame2", $signed(pcm_f), 1300);

    // Clip, both directions
    for (int i = 0; i < 4; i++) set_chan(i, 16'h4000, 32767);
    run_frame();
    run_frame();
    check_eq("clip_pos", $signed(pcm_f), 32767);
    check_eq("clip_flag", clip_f, 1);
    for (int i = 0; i < 4; i++) in_v[i] = -16'sd32768;
    run_frame();
    check_eq("clip_neg", $signed(pcm_f), -32768);
    pulse_clear();
    check_eq("clip_cleared", clip_f, 0);

    // Random mixes through the scoreboard
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++)
        set_chan(i, $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF));
      mute = 4'($urandom_range(0, 15));
      run_frame();
    end
    mute = 4'h0;
    pulse_clear();

    // Overrun: ticks at cycle 0 and 2, then an accepted tick at cycle 5
    push_expected();
    sample_tick = 1'b1; step();             // cycle 1
    sample_tick = 1'b0; step();             // cycle 2
    sample_tick = 1'b1; step();             // cycle 3
    sample_tick = 1'b0;
    check_eq("ovr_set", ovr_f, 1);
    clear_flags = 1'b1; step();             // cycle 4
    clear_flags = 1'b0;
    check_eq("ovr_clear", ovr_f, 0);
    step();                                 // cycle 5
    check_eq("ovr_valid_c5", valid_f, 1);
    push_expected();
    sample_tick = 1'b1; step();             // next frame cycle 1
    sample_tick = 1'b0;
    check_eq("ovr_c5_accepted", busy_f, 1);
    check_eq("ovr_c5_no_flag", ovr_f, 0);
    step();                                 // frame cycle 2
    sample_tick = 1'b1; clear_flags = 1'b1;
    step();                                 // frame cycle 3
    sample_tick = 1'b0; clear_flags = 1'b0;
    check_eq("ovr_set_wins", ovr_f, 1);
    step(); step();                         // frame cycle 5
    check_eq("ovr_valid_f2", valid_f, 1);
    step();
    pulse_clear();

    // Reset mid-frame: no valid, levels restart from 0
    sample_tick = 1'b1; step();             // cycle 1
    sample_tick = 1'b0; step();             // cycle 2
    step();                                 // cycle 3
    reset = 1'b1; step();                   // cycle 4
    reset = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) cur_m[d][i] = 0;
    check_eq("rst_mid_busy", busy_f, 0);
    check_eq("rst_mid_pcm", pcm_f, 0);
    check_eq("rst_mid_valid", valid_f, 0);
    for (int k = 0; k < 6; k++) step();
    for (int i = 0; i < 4; i++) set_chan(i, 16'h4000, 100 * (i + 1));
    run_frame();
    check_eq("rst_lvl_restart", $signed(pcm_f), 0);
    run_frame();
    check_eq("rst_next_frame", $signed(pcm_f), 1000);

    // Snapshot isolation
    set_chan(0, 16'h4000, 1000);
    for (int i = 1; i < 4; i++) set_chan(i, 0, 0);
    run_frame();
    push_expected();
    sample_tick = 1'b1; step();             // cycle 1
    sample_tick = 1'b0; step();             // cycle 2
    in_v[0] = 16'sd3000;
    step(); step(); step();                 // cycle 5
    check_eq("snap_valid", valid_f, 1);
    check_eq("snap_old", $signed(pcm_f), 1000);
    step();
    run_frame();
    check_eq("snap_new", $signed(pcm_f), 3000);

    // Ramp at default step, then mute ramp-down
    do_reset();
    set_chan(0, 16'h4000, 16384);
    for (int i = 1; i < 4; i++) set_chan(i, 0, 0);
    for (int k = 1; k <= 260; k++) begin
      run_frame();
      check_eq("ramp_up", $signed(pcm_s), (64 * (k - 1) > 16384) ? 16384 : 64 * (k - 1));
    end
    mute = 4'b0001;
    for (int k = 1; k <= 260; k++) begin
      run_frame();
      check_eq("ramp_down", $signed(pcm_s), (16384 - 64 * (k - 1) < 0) ? 0 : 16384 - 64 * (k - 1));
    end

    step(); step();
    check_eq("queue_f_empty", exp_f.size(), 0);
    check_eq("queue_s_empty", exp_s.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mixer_sequencer.md
# mixer_sequencer

Time-multiplexed four-channel mixer controller with per-channel level ramping. On each `sample_tick` it snapshots the four channel samples and runs them through one shared signed 16x16 multiply-accumulate, one channel per cycle. It saturates the Q16.0 result and issues a one-cycle `pcm_valid` strobe. It sits between the voice generators and the PCM output path, and its level ramp removes zipper noise on volume changes.

## Interface
- `RAMP_STEP`, default 16'd64: maximum change of the applied level per frame, Q2.14 (64 = 1/256 of unity).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset; one clock, and it is sampled on the rising edge of `clk`.
- `sample_tick`  in  1  frame start request, one cycle wide.
- `input_1`..`input_4`  in  16 each  signed Q16.0 channel samples.
- `lvl_1`..`lvl_4`  in  16 each  signed Q2.14 target levels (0x4000 = +1.0, 0xC000 = -1.0).
- `mute`  in  4  bit i-1 forces the target of channel i to 0.
- `clear_flags`  in  1  clears `clipped` and `overrun`.
- `pcm_out`  out  16  signed Q16.0 mixed sample, held between frames.
- `pcm_valid`  out  1  one-cycle strobe when `pcm_out` updates.
- `busy`  out  1  high while a frame is in progress.
- `clipped`  out  1  sticky; set when a frame saturated.
- `overrun`  out  1  sticky; set when a tick arrived while busy.

## Operation
- States: IDLE and MAC. A channel index `ch` runs 0..3.
- **IDLE, `sample_tick`=1:**
  - Latch `input_1..4` into the snapshot registers.
  - Clear the 34-bit accumulator.
  - Set `ch`=0 and go to MAC.
- **MAC, each cycle:**
  - Form the 32-bit signed product `cur_lvl[ch] * snap[ch]`, using the applied level from before this frame's update.
  - Sign-extend the product and add it to the accumulator.
  - Update `cur_lvl[ch]`. The target is 0 if muted, otherwise `lvl_ch` sampled this cycle. Compute `diff = target - cur` in 17-bit signed.
  - If |diff| <= `RAMP_STEP`, then `cur = target`; otherwise `cur` moves by ±`RAMP_STEP` toward the target.
- **MAC, `ch`=3:**
  - Compute `res = (acc + product) >>> 14` (arithmetic shift).
  - Saturate `res` to [-32768, 32767] and register it into `pcm_out`.
  - Pulse `pcm_valid`. Set `clipped` if saturation occurred.
  - Return to IDLE.
- `sample_tick` while in MAC is ignored, sets `overrun`, and leaves the running frame unaffected.
- `clear_flags` clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- Inputs changing after the snapshot do not affect the current frame. `lvl_*` and `mute` are sampled in each channel's MAC cycle.

## Timing
- Reset values:
  - `pcm_out`=0, `pcm_valid`=0, `busy`=0, `clipped`=0, `overrun`=0.
  - All `cur_lvl`=0; state IDLE; accumulator 0.
- Cycle timing, with the tick sampled at edge 0:
  - MAC runs in cycles 1-4, and `busy` is high in cycles 1-4.
  - `pcm_out` updates and `pcm_valid` is high in cycle 5.
  - Latency from tick to valid is 5 cycles.
- Minimum tick spacing is 5 cycles. A tick in cycle 5 is accepted with no overrun.
- Reset during MAC aborts the frame: no `pcm_valid`, and all registers return to their reset values. The next tick starts a normal frame.
- A level change reaches its target in ceil(|diff| / `RAMP_STEP`) frames. From reset at default step, unity gain takes 256 frames.
- Arithmetic widths:
  - Products are 32-bit signed.
  - The accumulator is 34-bit signed, so 4x(-32768 x -32768) cannot wrap.
  - Saturation is applied only on the final value.

## Test plan
- **Instant gain** (`RAMP_STEP`=0x8000):
  - Set `lvl_1..4` = 0x4000, 0x2000, 0x2000, 0xC000 and `input_1..4` = 1000, 2000, -400, 500.
  - Frame 1 gives `pcm_out`=0, because the levels start at 0.
  - Frame 2 gives `pcm_out`=1300, `pcm_valid` high for exactly 1 cycle, 5 cycles after the tick.
- **Clip** (instant gain, all levels 0x4000):
  - All inputs 32767: frame 2 gives 32767 and `clipped`=1.
  - All inputs -32768: gives -32768.
  - `clear_flags` then gives `clipped`=0.
- **Ramp** (default step):
  - Set `lvl_1`=0x4000, `input_1`=16384, other levels 0.
  - Frame k gives 64*(k-1) until 16384 at frame 257, then stays flat.
  - Asserting `mute[0]` afterward decreases the output by 64 per frame down to 0.
- **Overrun:**
  - Ticks at cycles 0 and 2 give a single `pcm_valid` at cycle 5 and `overrun`=1.
  - A tick at cycle 5 is accepted with no further overrun.
- **Reset mid-frame:**
  - Reset at cycle 3 gives no `pcm_valid`; `pcm_out`=0, `busy`=0, and levels restart from 0.
  - A following tick produces a valid frame 5 cycles later.
- **Snapshot isolation:**
  - Change `input_1` in cycle 2 of a frame.
  - The result reflects the value at the tick, and the next frame uses the new value.
